mem_access_unit: RTL and testbench

Load/store front end for the 16-bit FSM CPU, placed between the core's execute state machine and `data_memory`. It accepts one byte-addressed load or store at a time over a valid/ready handshake and drives the word-wide memory port. Byte stores are done as read-modify-write. Every accepted request returns exactly one response, with an error flag for misaligned word accesses.

---
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the core-side load/store handshake and the word-wide data_memory port.
// master = execute FSM side, slave = mem_access_unit, mem = data_memory side.
interface mem_access_unit_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_byte;
  logic          req_signed;
  logic [AW:0]   req_addr;
  logic [15:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [15:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_write_data;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [15:0]   mem_read_data;

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready,
  // a response on an edge where resp_valid && resp_ready; the sender holds its
  // payload stable and valid high until that edge.
  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, resp_ready,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_read_en, mem_write_en
  );

  modport mem (
    input  mem_address, mem_write_data, mem_read_en, mem_write_en,
    output mem_read_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: one byte-addressed request at a time, word-wide memory port,
// byte stores as read-modify-write, misaligned word accesses answered with an error.
module mem_access_unit #(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_MERGE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_byte;
  logic          r_signed;
  logic          r_lane;
  logic [7:0]    r_wbyte;
  logic          r_resp_valid;
  logic [15:0]   r_resp_rdata;
  logic          r_resp_err;
  logic [AW-1:0] r_mem_address;
  logic [15:0]   r_mem_write_data;
  logic          r_mem_read_en;
  logic          r_mem_write_en;

  logic [7:0]    w_lane_byte;
  logic [15:0]   w_load_result;
  logic [15:0]   w_merged;

  // Lane select, extension and merge only look at read_data in READ/MERGE,
  // the only states in which the memory drives it.
  always_comb begin
    w_lane_byte   = r_lane ? bus.mem_read_data[15:8] : bus.mem_read_data[7:0];
    w_load_result = bus.mem_read_data;
    if (r_byte) begin
      w_load_result = {{8{r_signed & w_lane_byte[7]}}, w_lane_byte};
    end
    w_merged = r_lane ? {r_wbyte, bus.mem_read_data[7:0]}
                      : {bus.mem_read_data[15:8], r_wbyte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_byte           <= 1'b0;
      r_signed         <= 1'b0;
      r_lane           <= 1'b0;
      r_wbyte          <= 8'h00;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= 16'h0000;
      r_resp_err       <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= 16'h0000;
      r_mem_read_en    <= 1'b0;
      r_mem_write_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_byte        <= bus.req_byte;
            r_signed      <= bus.req_signed;
            r_lane        <= bus.req_addr[0];
            r_wbyte       <= bus.req_wdata[7:0];
            r_mem_address <= bus.req_addr[AW:1];
            if (!bus.req_byte && bus.req_addr[0]) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 16'h0000;
            end else if (!bus.req_write) begin
              r_state       <= S_READ;
              r_mem_read_en <= 1'b1;
            end else if (!bus.req_byte) begin
              r_state          <= S_WRITE;
              r_mem_write_en   <= 1'b1;
              r_mem_write_data <= bus.req_wdata;
            end else begin
              r_state       <= S_MERGE;
              r_mem_read_en <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_mem_read_en <= 1'b0;
          r_resp_valid  <= 1'b1;
          r_resp_rdata  <= w_load_result;
          r_resp_err    <= 1'b0;
          r_state       <= S_RESP;
        end
        S_MERGE: begin
          r_mem_read_en    <= 1'b0;
          r_mem_write_en   <= 1'b1;
          r_mem_write_data <= w_merged;
          r_state          <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_write_en <= 1'b0;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= 16'h0000;
          r_resp_err     <= 1'b0;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // req_ready is forced low while reset is asserted so nothing is accepted in that cycle.
  assign bus.req_ready      = (r_state == S_IDLE) & ~rst;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_err       = r_resp_err;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_write_data = r_mem_write_data;
  assign bus.mem_read_en    = r_mem_read_en;
  assign bus.mem_write_en   = r_mem_write_en;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of loads/stores plus hand-written
// sequences for reset, response backpressure and reset in the middle of a byte store.
module tb_mem_access_unit;
  localparam int AW = 8;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_cmp;
  int         n_fail;
  logic [15:0] mem_array [256];

  mem_access_unit_if #(.AW(AW)) bus ();

  mem_access_unit #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: combinational read while read_en, write at the edge
  assign bus.mem_read_data = bus.mem_read_en ? mem_array[bus.mem_address] : 16'h0000;
  always @(posedge clk) begin
    if (bus.mem_write_en) mem_array[bus.mem_address] <= bus.mem_write_data;
  end

  typedef struct {
    logic        wr;
    logic        byt;
    logic        sgn;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic wr, input logic byt, input logic sgn,
                              input logic [8:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr);
    vec_t v;
    v.wr = wr; v.byt = byt; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its response, complete the response handshake.
  task automatic do_req(input logic wr, input logic byt, input logic sgn,
                        input logic [8:0] addr, input logic [15:0] wdata,
                        output logic got, output logic [15:0] rdata, output logic err,
                        output int lat, output int rd, output int wcnt,
                        output logic addr_ok, output logic excl_ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_byte   = byt;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; rd = 0; wcnt = 0; addr_ok = 1'b1; excl_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_read_en) rd++;
      if (bus.mem_write_en) wcnt++;
      if ((bus.mem_read_en || bus.mem_write_en) && bus.mem_address !== addr[8:1]) addr_ok = 1'b0;
      if (bus.mem_read_en && bus.mem_write_en) excl_ok = 1'b0;
    end while (!bus.resp_valid && lat < 20);
    got   = bus.resp_valid;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic        got;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wcnt;
    logic        addr_ok;
    logic        excl_ok;
    int          t;

    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem_array[i] = 16'h0000;

    vecs[0]  = mk(1, 0, 0, 9'h010, 16'hBEEF, 16'h0000, 0, 2, 0, 1);
    vecs[1]  = mk(0, 0, 0, 9'h010, 16'h0000, 16'hBEEF, 0, 2, 1, 0);
    vecs[2]  = mk(1, 0, 0, 9'h010, 16'h80F0, 16'h0000, 0, 2, 0, 1);
    vecs[3]  = mk(0, 1, 1, 9'h011, 16'h0000, 16'hFF80, 0, 2, 1, 0);
    vecs[4]  = mk(0, 1, 0, 9'h011, 16'h0000, 16'h0080, 0, 2, 1, 0);
    vecs[5]  = mk(0, 1, 1, 9'h010, 16'h0000, 16'hFFF0, 0, 2, 1, 0);
    vecs[6]  = mk(0, 1, 0, 9'h010, 16'h0000, 16'h00F0, 0, 2, 1, 0);
    vecs[7]  = mk(1, 0, 0, 9'h006, 16'h1234, 16'h0000, 0, 2, 0, 1);
    vecs[8]  = mk(1, 1, 0, 9'h007, 16'h00AB, 16'h0000, 0, 3, 1, 1);
    vecs[9]  = mk(0, 0, 0, 9'h006, 16'h0000, 16'hAB34, 0, 2, 1, 0);
    vecs[10] = mk(1, 1, 0, 9'h006, 16'h99CD, 16'h0000, 0, 3, 1, 1);
    vecs[11] = mk(0, 0, 0, 9'h006, 16'h0000, 16'hABCD, 0, 2, 1, 0);
    vecs[12] = mk(0, 0, 0, 9'h005, 16'h0000, 16'h0000, 1, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 9'h007, 16'h5555, 16'h0000, 1, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 9'h006, 16'h0000, 16'hABCD, 0, 2, 1, 0);
    vecs[15] = mk(0, 1, 1, 9'h007, 16'h0000, 16'hFFAB, 0, 2, 1, 0);

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready",    {31'd0, bus.req_ready},    32'd0);
    chk("rst_resp_valid",   {31'd0, bus.resp_valid},   32'd0);
    chk("rst_resp_rdata",   {16'd0, bus.resp_rdata},   32'd0);
    chk("rst_resp_err",     {31'd0, bus.resp_err},     32'd0);
    chk("rst_mem_address",  {24'd0, bus.mem_address},  32'd0);
    chk("rst_mem_wdata",    {16'd0, bus.mem_write_data}, 32'd0);
    chk("rst_mem_read_en",  {31'd0, bus.mem_read_en},  32'd0);
    chk("rst_mem_write_en", {31'd0, bus.mem_write_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].wr, vecs[i].byt, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             got, rdata, err, lat, rd, wcnt, addr_ok, excl_ok);
      chk($sformatf("v%0d_resp_seen", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_read_cycles", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_write_cycles", i), wcnt, vecs[i].exp_wr);
      chk($sformatf("v%0d_mem_address", i), {31'd0, addr_ok}, 32'd1);
      chk($sformatf("v%0d_rd_wr_exclusive", i), {31'd0, excl_ok}, 32'd1);
    end

    // Backpressure: word load 0x10 (0x80F0), response held 5 cycles while a
    // second load to 0x06 waits on req_valid.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = 9'h010; bus.req_wdata = 16'h0000;
    @(posedge clk);
    #1 bus.req_addr = 9'h006;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.resp_valid && t < 20);
    chk("bp_resp_seen", {31'd0, bus.resp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_c%0d_valid", c), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp_c%0d_rdata", c), {16'd0, bus.resp_rdata}, 32'h80F0);
      chk($sformatf("bp_c%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("bp_c%0d_mem_idle", c), {30'd0, bus.mem_read_en, bus.mem_write_en}, 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_req_ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_valid_dropped", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_read_en", {31'd0, bus.mem_read_en}, 32'd1);
    chk("bp_second_address", {24'd0, bus.mem_address}, 32'h03);
    @(negedge clk);
    chk("bp_second_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("bp_second_rdata", {16'd0, bus.resp_rdata}, 32'hABCD);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;

    // Reset while a byte store to 0x06 sits in MERGE.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b1;
    bus.req_signed = 1'b0; bus.req_addr = 9'h006; bus.req_wdata = 16'h0011;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_in_merge_read_en", {31'd0, bus.mem_read_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_req_ready",  {31'd0, bus.req_ready},    32'd0);
    chk("rmw_rst_valid",      {31'd0, bus.resp_valid},   32'd0);
    chk("rmw_rst_rdata",      {16'd0, bus.resp_rdata},   32'd0);
    chk("rmw_rst_mem_en",     {30'd0, bus.mem_read_en, bus.mem_write_en}, 32'd0);
    chk("rmw_rst_mem_addr",   {24'd0, bus.mem_address},  32'd0);
    chk("rmw_rst_mem_wdata",  {16'd0, bus.mem_write_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rmw_word_untouched", {16'd0, mem_array[3]}, 32'hABCD);
    do_req(1'b0, 1'b0, 1'b0, 9'h006, 16'h0000, got, rdata, err, lat, rd, wcnt, addr_ok, excl_ok);
    chk("rmw_reload_seen",  {31'd0, got},    32'd1);
    chk("rmw_reload_rdata", {16'd0, rdata},  32'hABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
